// File: rtl/ddr_tx_serializer_if.sv
// ddr_tx_serializer_if
//   Word handshake and DDR output bundle for ddr_tx_serializer.
//   id/iv/ir : parallel word, valid, ready (accept on iv & ir)
//   o        : DDR pair to ODDR, o[0] rising-edge bit, o[1] falling-edge bit
//   fs       : frame strobe, high on beat 0 of each word
//   active   : high while a word beat is on o
//   master : word source / output observer
//   slave  : the serializer itself
interface ddr_tx_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] id;
  logic             iv;
  logic             ir;
  logic [1:0]       o;
  logic             fs;
  logic             active;

  modport master (
    output id, iv,
    input  ir, o, fs, active
  );

  modport slave (
    input  id, iv,
    output ir, o, fs, active
  );
endinterface

// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer
//   Source-synchronous DDR transmit serializer. Accepts WIDTH-bit words over a
//   valid/ready handshake and emits them two bits per clock, MSB first, on a
//   registered 2-bit bus feeding an ODDR (SAME_EDGE) primitive.
//   Ports:
//     c      : clock, all logic on rising edge
//     r      : synchronous active-high reset
//     bus    : ddr_tx_serializer_if.slave (id, iv, ir, o, fs, active)
//     train  : (only with DDR_TX_TRAIN_EN) request forwarded-clock pattern
//   Optional feature macro: DDR_TX_TRAIN_EN adds the train input and a TRAIN
//   state driving o = 2'b10 for receiver IDELAY alignment.
//   WIDTH must be even and >= 4; the interface WIDTH must match.
module ddr_tx_serializer #(
  parameter int         WIDTH = 8,
  parameter logic [1:0] IDLE  = 2'b00
) (
  input  logic                  c,
  input  logic                  r,
`ifdef DDR_TX_TRAIN_EN
  input  logic                  train,
`endif
  ddr_tx_serializer_if.slave    bus
);

  localparam int BEATS = WIDTH / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef DDR_TX_TRAIN_EN
  localparam logic [1:0] S_TRAIN = 2'd2;
`endif

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] sr_q,     sr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [1:0]       o_q,      o_d;
  logic             fs_q,     fs_d;
  logic             active_q, active_d;

  logic last_beat;
  logic ready;
  logic accept;
  logic train_req;

`ifdef DDR_TX_TRAIN_EN
  assign train_req = train;
`else
  assign train_req = 1'b0;
`endif

  assign last_beat = (state_q == S_SHIFT) && (cnt_q == CW'(BEATS - 1));
  // A pending train request takes the slot a new word would otherwise use,
  // so ready is withheld while train is high.
  assign ready     = ~r & ~train_req & ((state_q == S_IDLE) | last_beat);
  assign accept    = bus.iv & ready;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    o_d      = IDLE;
    fs_d     = 1'b0;
    active_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d    = bus.id;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else if (train_req) begin
`ifdef DDR_TX_TRAIN_EN
          state_d = S_TRAIN;
`endif
        end
      end

      S_SHIFT: begin
        // Top two bits of the shift register form the current beat;
        // o[0] carries the higher (earlier, rising-edge) bit.
        o_d      = {sr_q[WIDTH-2], sr_q[WIDTH-1]};
        fs_d     = (cnt_q == '0);
        active_d = 1'b1;
        sr_d     = {sr_q[WIDTH-3:0], 2'b00};
        cnt_d    = cnt_q + CW'(1);
        if (last_beat) begin
          if (accept) begin
            sr_d    = bus.id;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end else if (train_req) begin
`ifdef DDR_TX_TRAIN_EN
            state_d = S_TRAIN;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end

`ifdef DDR_TX_TRAIN_EN
      S_TRAIN: begin
        o_d = 2'b10;
        if (!train_req) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      o_q      <= IDLE;
      fs_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      fs_q     <= fs_d;
      active_q <= active_d;
    end
  end

  assign bus.ir     = ready;
  assign bus.o      = o_q;
  assign bus.fs     = fs_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb_ddr_tx_serializer
//   Directed bench for ddr_tx_serializer (WIDTH=8, IDLE=2'b00). Inputs change
//   1 time unit after each rising edge; registered outputs and ir are sampled
//   at that same point, before the inputs for the next edge are applied.
module tb_ddr_tx_serializer;

  logic c;
  logic r;
`ifdef DDR_TX_TRAIN_EN
  logic train;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  ddr_tx_serializer_if #(.WIDTH(8)) bus ();

  ddr_tx_serializer #(
    .WIDTH (8),
    .IDLE  (2'b00)
  ) dut (
    .c     (c),
    .r     (r),
`ifdef DDR_TX_TRAIN_EN
    .train (train),
`endif
    .bus   (bus)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] eo, input logic efs,
                           input logic eact, input logic eir);
    check({tag, ".o"},      32'(bus.o),      32'(eo));
    check({tag, ".fs"},     32'(bus.fs),     32'(efs));
    check({tag, ".active"}, 32'(bus.active), 32'(eact));
    check({tag, ".ir"},     32'(bus.ir),     32'(eir));
  endtask

  // Send one word from IDLE with iv dropped right after acceptance; the
  // four expected beats are supplied by the caller.
  task automatic xmit(input string tag, input logic [7:0] w, input logic [1:0] e0,
                      input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3);
    logic [1:0] eb [4];
    eb[0] = e0; eb[1] = e1; eb[2] = e2; eb[3] = e3;
    check({tag, ".ready_idle"}, 32'(bus.ir), 32'd1);
    bus.id = w;
    bus.iv = 1'b1;
    tick();
    bus.iv = 1'b0;
    bus.id = 8'h00;
    check_out({tag, ".acc"}, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("%s.beat%0d", tag, k), eb[k], (k == 0), 1'b1, (k >= 2));
    end
    tick();
    check_out({tag, ".after"}, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  // Back-to-back expectations, sample t = 0 is right after the first accept.
  logic [1:0] b2b_o   [10] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic       b2b_fs  [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
  logic       b2b_act [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic       b2b_ir  [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    n_checks = 0;
    n_errors = 0;
    r        = 1'b1;
    bus.iv   = 1'b1;
    bus.id   = 8'hFF;
`ifdef DDR_TX_TRAIN_EN
    train    = 1'b0;
`endif

    // Reset held 3 cycles with iv high: nothing accepted, outputs idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("reset%0d", i), 2'b00, 1'b0, 1'b0, 1'b0);
    end
    r      = 1'b0;
    bus.iv = 1'b0;
    tick();
    check_out("post_reset", 2'b00, 1'b0, 1'b0, 1'b1);

    // Single word 8'hB4 = 1011_0100.
    xmit("b4", 8'hB4, 2'b01, 2'b11, 2'b10, 2'b00);

    // Back-to-back 8'hFF then 8'h00; 8'h3C is offered while ir=0 and ignored.
    bus.id = 8'hFF;
    bus.iv = 1'b1;
    tick();
    for (int t = 0; t < 10; t++) begin
      check_out($sformatf("b2b%0d", t), b2b_o[t], b2b_fs[t], b2b_act[t], b2b_ir[t]);
      if (t == 0) bus.id = 8'h3C;
      if (t == 2) bus.id = 8'h00;
      if (t == 4) begin
        bus.iv = 1'b0;
        bus.id = 8'hFF;
      end
      if (t < 9) tick();
    end

    // Reset during beat 1 of 8'hA5 = 1010_0101.
    bus.id = 8'hA5;
    bus.iv = 1'b1;
    tick();
    bus.iv = 1'b0;
    tick();
    check_out("a5.beat0", 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("a5.beat1", 2'b01, 1'b0, 1'b1, 1'b0);
    r      = 1'b1;
    bus.iv = 1'b1;
    tick();
    check_out("abort", 2'b00, 1'b0, 1'b0, 1'b0);
    r      = 1'b0;
    bus.iv = 1'b0;
    tick();
    check_out("abort1", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("abort2", 2'b00, 1'b0, 1'b0, 1'b1);

    // Clean word after the abort: 8'h1E = 0001_1110.
    xmit("1e", 8'h1E, 2'b00, 2'b10, 2'b11, 2'b01);

`ifdef DDR_TX_TRAIN_EN
    // Train raised mid-word: word completes, then 2'b10 pattern with ir=0.
    bus.id = 8'hB4;
    bus.iv = 1'b1;
    tick();
    bus.iv = 1'b0;
    train  = 1'b1;
    tick();
    check_out("tr.beat0", 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("tr.beat1", 2'b11, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("tr.beat2", 2'b10, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("tr.beat3", 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("tr.pat%0d", i), 2'b10, 1'b0, 1'b0, 1'b0);
    end
    train = 1'b0;
    tick();
    check("tr.exit_ir", 32'(bus.ir), 32'd1);
    tick();
    check_out("tr.idle", 2'b00, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
